alu_rs: RTL and testbench

//  ALU reservation station: receiving end of the dispatcher's ALU port. Holds dispatched ALU/jump ops, wakes

---
 rtl/alu_rs_pkg.sv | 37 +++
 rtl/alu_rs_select.sv | 34 +++
 rtl/alu_rs.sv | 144 ++++++++++++++
 tb/tb_alu_rs.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, tag constants, entry-state encoding and the CDB wakeup helper.
package alu_rs_pkg;
  localparam int ENTRIES = 8;
  localparam int RW = $clog2(ENTRIES);
  localparam int DATA_W = 32;
  localparam int TAG_W = 4;
  localparam int OP_W = 6;
  localparam int ADDR_W = 32;
  localparam logic [TAG_W-1:0] TAG_FREE = '1;
  localparam logic ALU_PREFIX = 1'b0;
  localparam logic LS_PREFIX = 1'b1;
  localparam logic [OP_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opnd_t;

  // The ALU bus is checked last so it wins if both buses carry the same tag.
  function automatic opnd_t wake(input opnd_t o,
                                 input logic a_en, input logic [TAG_W-1:0] a_tag,
                                 input logic [DATA_W-1:0] a_data,
                                 input logic l_en, input logic [TAG_W-1:0] l_tag,
                                 input logic [DATA_W-1:0] l_data);
    opnd_t r;
    r = o;
    if (o.tag != TAG_FREE && l_en && l_tag == o.tag) r = '{tag: TAG_FREE, data: l_data};
    if (o.tag != TAG_FREE && a_en && a_tag == o.tag) r = '{tag: TAG_FREE, data: a_data};
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: picks one ready entry per cycle; oldest-first when ALU_RS_OLDEST_FIRST_EN is defined,
// otherwise lowest index.
module alu_rs_select
  import alu_rs_pkg::*;
(
  input  logic [ENTRIES-1:0]         i_ready,
`ifdef ALU_RS_OLDEST_FIRST_EN
  input  logic [ENTRIES-1:0][RW-1:0] i_age,
`endif
  output logic                       o_valid,
  output logic [RW-1:0]              o_idx
);
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [RW-1:0] w_best;
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    w_best = '0;
    for (int k = 0; k < ENTRIES; k++)
      if (i_ready[k] && (!o_valid || i_age[k] < w_best)) begin
        o_valid = 1'b1;
        o_idx = RW'(k);
        w_best = i_age[k];
      end
  end
`else
  always_comb begin
    o_valid = |i_ready;
    o_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--)
      if (i_ready[k]) o_idx = RW'(k);
  end
`endif
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup, self-allocated entries and single issue per cycle.
// Build option ALU_RS_OLDEST_FIRST_EN selects oldest-ready issue instead of lowest-index.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ALUen,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [DATA_W-1:0] ALUoperandO,
  input  logic [DATA_W-1:0] ALUoperandT,
  input  logic [TAG_W-1:0]  ALUtagO,
  input  logic [TAG_W-1:0]  ALUtagT,
  input  logic [TAG_W-1:0]  ALUtagW,
  input  logic [ADDR_W-1:0] ALUaddr,
  input  logic              misTaken,
  input  logic              aluCdbEn,
  input  logic [TAG_W-1:0]  aluCdbTag,
  input  logic [DATA_W-1:0] aluCdbData,
  input  logic              lsCdbEn,
  input  logic [TAG_W-1:0]  lsCdbTag,
  input  logic [DATA_W-1:0] lsCdbData,
  output logic [RW-1:0]     ALUfreeTag,
  output logic              rsFull,
  output logic              exEn,
  output logic [OP_W-1:0]   exOp,
  output logic [DATA_W-1:0] exA,
  output logic [DATA_W-1:0] exB,
  output logic [TAG_W-1:0]  exTagW,
  output logic [ADDR_W-1:0] exAddr
);
  ent_state_e        r_state [ENTRIES];
  logic [OP_W-1:0]   r_op    [ENTRIES];
  logic [ADDR_W-1:0] r_addr  [ENTRIES];
  opnd_t             r_opo   [ENTRIES];
  opnd_t             r_opt   [ENTRIES];
  logic              r_ex_en;
  logic [OP_W-1:0]   r_ex_op;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [TAG_W-1:0]  r_ex_tagw;
  logic [ADDR_W-1:0] r_ex_addr;
  logic [RW-1:0]      w_root;
  logic               w_disp;
  logic [ENTRIES-1:0] w_ready;
  logic [ENTRIES-1:0] w_free;
  logic [ENTRIES-1:0] w_empty;
  logic               w_gnt_v;
  logic [RW-1:0]      w_gnt_idx;
  assign w_root = ALUtagW[RW-1:0];
  assign w_disp = ALUen && !misTaken && r_state[w_root] == ST_EMPTY;
  always_comb begin
    ALUfreeTag = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_ready[k] = r_state[k] == ST_WAIT && r_opo[k].tag == TAG_FREE && r_opt[k].tag == TAG_FREE;
      w_free[k] = aluCdbEn && aluCdbTag == {ALU_PREFIX, RW'(k)} && r_state[k] == ST_ISSUED;
      w_empty[k] = r_state[k] == ST_EMPTY;
    end
    for (int k = ENTRIES - 1; k >= 0; k--)
      if (w_empty[k]) ALUfreeTag = RW'(k);
  end
  assign rsFull = ~|w_empty;
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [ENTRIES-1:0][RW-1:0] r_age;
  logic [RW:0]                w_count;
  logic [RW-1:0]              w_free_age;
  logic [RW-1:0]              w_new_age;
  always_comb begin
    w_count = '0;
    w_free_age = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_count = w_count + (RW+1)'(r_state[k] != ST_EMPTY);
      if (w_free[k]) w_free_age = r_age[k];
    end
    w_new_age = RW'(w_count - (RW+1)'(|w_free));
  end
  // Age 0 is the oldest occupant; a free closes the gap left behind it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_age <= '0;
    else if (misTaken) r_age <= '0;
    else
      for (int k = 0; k < ENTRIES; k++)
        if (w_disp && w_root == RW'(k)) r_age[k] <= w_new_age;
        else if (r_state[k] != ST_EMPTY && |w_free && r_age[k] > w_free_age) r_age[k] <= r_age[k] - 1'b1;
  alu_rs_select u_select (.i_ready(w_ready), .i_age(r_age), .o_valid(w_gnt_v), .o_idx(w_gnt_idx));
`else
  alu_rs_select u_select (.i_ready(w_ready), .o_valid(w_gnt_v), .o_idx(w_gnt_idx));
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_state[k] <= ST_EMPTY;
        r_op[k] <= NOP;
        r_addr[k] <= '0;
        r_opo[k] <= '{tag: TAG_FREE, data: '0};
        r_opt[k] <= '{tag: TAG_FREE, data: '0};
      end
      r_ex_en <= 1'b0;
      r_ex_op <= NOP;
      r_ex_a <= '0;
      r_ex_b <= '0;
      r_ex_tagw <= TAG_FREE;
      r_ex_addr <= '0;
    end else if (misTaken) begin
      for (int k = 0; k < ENTRIES; k++) r_state[k] <= ST_EMPTY;
      r_ex_en <= 1'b0;
    end else begin
      r_ex_en <= w_gnt_v;
      if (w_gnt_v) begin
        r_ex_op <= r_op[w_gnt_idx];
        r_ex_a <= r_opo[w_gnt_idx].data;
        r_ex_b <= r_opt[w_gnt_idx].data;
        r_ex_tagw <= {ALU_PREFIX, w_gnt_idx};
        r_ex_addr <= r_addr[w_gnt_idx];
        r_state[w_gnt_idx] <= ST_ISSUED;
      end
      for (int k = 0; k < ENTRIES; k++) begin
        if (r_state[k] == ST_WAIT) begin
          r_opo[k] <= wake(r_opo[k], aluCdbEn, aluCdbTag, aluCdbData, lsCdbEn, lsCdbTag, lsCdbData);
          r_opt[k] <= wake(r_opt[k], aluCdbEn, aluCdbTag, aluCdbData, lsCdbEn, lsCdbTag, lsCdbData);
        end
        if (w_free[k]) r_state[k] <= ST_EMPTY;
        if (w_disp && w_root == RW'(k)) begin
          r_state[k] <= ST_WAIT;
          r_op[k] <= ALUop;
          r_addr[k] <= ALUaddr;
          r_opo[k] <= wake('{tag: ALUtagO, data: ALUoperandO}, aluCdbEn, aluCdbTag, aluCdbData, lsCdbEn, lsCdbTag, lsCdbData);
          r_opt[k] <= wake('{tag: ALUtagT, data: ALUoperandT}, aluCdbEn, aluCdbTag, aluCdbData, lsCdbEn, lsCdbTag, lsCdbData);
        end
      end
    end
  assign exEn = r_ex_en;
  assign exOp = r_ex_op;
  assign exA = r_ex_a;
  assign exB = r_ex_b;
  assign exTagW = r_ex_tagw;
  assign exAddr = r_ex_addr;
  a_disp_empty: assert property (@(posedge clk) disable iff (!rst_n)
    ALUen && !misTaken |-> r_state[w_root] == ST_EMPTY && ALUtagW[TAG_W-1] == ALU_PREFIX);
  a_cdb_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    aluCdbEn && lsCdbEn |-> aluCdbTag != lsCdbTag);
  a_ls_prefix: assert property (@(posedge clk) disable iff (!rst_n)
    lsCdbEn |-> lsCdbTag[TAG_W-1] == LS_PREFIX);
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs (expected issue order follows ALU_RS_OLDEST_FIRST_EN).
module tb_alu_rs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ALUen = 1'b0;
  logic [5:0]  ALUop = '0;
  logic [31:0] ALUoperandO = '0, ALUoperandT = '0;
  logic [3:0]  ALUtagO = 4'hF, ALUtagT = 4'hF, ALUtagW = '0;
  logic [31:0] ALUaddr = '0;
  logic        misTaken = 1'b0;
  logic        aluCdbEn = 1'b0, lsCdbEn = 1'b0;
  logic [3:0]  aluCdbTag = '0, lsCdbTag = 4'h8;
  logic [31:0] aluCdbData = '0, lsCdbData = '0;
  logic [2:0]  ALUfreeTag;
  logic        rsFull, exEn;
  logic [5:0]  exOp;
  logic [31:0] exA, exB, exAddr;
  logic [3:0]  exTagW;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .ALUen(ALUen), .ALUop(ALUop), .ALUoperandO(ALUoperandO),
    .ALUoperandT(ALUoperandT), .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW),
    .ALUaddr(ALUaddr), .misTaken(misTaken), .aluCdbEn(aluCdbEn), .aluCdbTag(aluCdbTag),
    .aluCdbData(aluCdbData), .lsCdbEn(lsCdbEn), .lsCdbTag(lsCdbTag), .lsCdbData(lsCdbData),
    .ALUfreeTag(ALUfreeTag), .rsFull(rsFull), .exEn(exEn), .exOp(exOp), .exA(exA), .exB(exB),
    .exTagW(exTagW), .exAddr(exAddr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] tw, input logic [3:0] to, input logic [31:0] a,
                      input logic [3:0] tt, input logic [31:0] b, input logic [5:0] op);
    ALUen = 1'b1; ALUtagW = tw; ALUtagO = to; ALUoperandO = a; ALUtagT = tt; ALUoperandT = b;
    ALUop = op; ALUaddr = 32'h1000 + 32'(tw) * 4;
    tick();
    ALUen = 1'b0; aluCdbEn = 1'b0; lsCdbEn = 1'b0;
  endtask

  task automatic ls_bcast(input logic [3:0] t, input logic [31:0] d);
    lsCdbEn = 1'b1; lsCdbTag = t; lsCdbData = d;
    tick();
    lsCdbEn = 1'b0;
  endtask

  task automatic alu_bcast(input logic [3:0] t, input logic [31:0] d);
    aluCdbEn = 1'b1; aluCdbTag = t; aluCdbData = d;
    tick();
    aluCdbEn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL rst_exEn got %0b want 0", exEn); end
    n_cmp++; if (exTagW !== 4'hF) begin n_bad++; $display("FAIL rst_exTagW got %h want f", exTagW); end
    n_cmp++; if (exOp !== 6'h0 || exA !== 32'h0 || exB !== 32'h0 || exAddr !== 32'h0) begin n_bad++; $display("FAIL rst_exdata got op=%h a=%h b=%h addr=%h want 0", exOp, exA, exB, exAddr); end
    n_cmp++; if (rsFull !== 1'b0 || ALUfreeTag !== 3'd0) begin n_bad++; $display("FAIL rst_free got full=%0b free=%0d want 0/0", rsFull, ALUfreeTag); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_issue();
    disp(4'h0, 4'hF, 32'd5, 4'hF, 32'd7, 6'h01);
    n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL issue_early got %0b want 0", exEn); end
    n_cmp++; if (ALUfreeTag !== 3'd1) begin n_bad++; $display("FAIL issue_alloc got %0d want 1", ALUfreeTag); end
    tick();
    n_cmp++; if (exEn !== 1'b1 || exA !== 32'd5 || exB !== 32'd7 || exTagW !== 4'h0 || exOp !== 6'h01 || exAddr !== 32'h1000)
      begin n_bad++; $display("FAIL issue_out got en=%0b a=%0d b=%0d tw=%h op=%h addr=%h want 1/5/7/0/01/1000", exEn, exA, exB, exTagW, exOp, exAddr); end
    tick();
    n_cmp++; if (exEn !== 1'b0 || exA !== 32'd5) begin n_bad++; $display("FAIL issue_pulse got en=%0b a=%0d want 0/5", exEn, exA); end
    n_cmp++; if (ALUfreeTag !== 3'd1) begin n_bad++; $display("FAIL issued_held got %0d want 1", ALUfreeTag); end
    alu_bcast(4'h0, 32'd12);
    n_cmp++; if (ALUfreeTag !== 3'd0 || rsFull !== 1'b0) begin n_bad++; $display("FAIL issue_free got free=%0d full=%0b want 0/0", ALUfreeTag, rsFull); end
  endtask

  task automatic test_wakeup();
    disp(4'h0, 4'h9, 32'd0, 4'hF, 32'd3, 6'h02);
    tick();
    n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL wake_wait got %0b want 0", exEn); end
    ls_bcast(4'h9, 32'h20);
    n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL wake_noforward got %0b want 0", exEn); end
    tick();
    n_cmp++; if (exEn !== 1'b1 || exA !== 32'h20 || exB !== 32'd3) begin n_bad++; $display("FAIL wake_issue got en=%0b a=%h b=%h want 1/20/3", exEn, exA, exB); end
    alu_bcast(4'h0, 32'd0);
    lsCdbEn = 1'b1; lsCdbTag = 4'h9; lsCdbData = 32'h44;
    disp(4'h0, 4'h9, 32'd0, 4'h6, 32'd0, 6'h03);
    alu_bcast(4'h6, 32'h66);
    n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL capture_wait got %0b want 0", exEn); end
    tick();
    n_cmp++; if (exEn !== 1'b1 || exA !== 32'h44 || exB !== 32'h66) begin n_bad++; $display("FAIL capture_issue got en=%0b a=%h b=%h want 1/44/66", exEn, exA, exB); end
    alu_bcast(4'h0, 32'd0);
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (ALUfreeTag !== 3'(k) || rsFull !== 1'b0) begin n_bad++; $display("FAIL fill_%0d got free=%0d full=%0b want %0d/0", k, ALUfreeTag, rsFull, k); end
      disp(4'(k), 4'h9, 32'd0, 4'hF, 32'(k), 6'h04);
    end
    n_cmp++; if (rsFull !== 1'b1) begin n_bad++; $display("FAIL full got %0b want 1", rsFull); end
    ls_bcast(4'h9, 32'h11);
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'(k) || exA !== 32'h11 || exB !== 32'(k))
        begin n_bad++; $display("FAIL drain_%0d got en=%0b tw=%h a=%h b=%h want 1/%h/11/%h", k, exEn, exTagW, exA, exB, k, k); end
    end
    tick();
    n_cmp++; if (exEn !== 1'b0 || rsFull !== 1'b1) begin n_bad++; $display("FAIL drained got en=%0b full=%0b want 0/1", exEn, rsFull); end
    alu_bcast(4'h3, 32'd0);
    n_cmp++; if (rsFull !== 1'b0 || ALUfreeTag !== 3'd3) begin n_bad++; $display("FAIL free3 got full=%0b free=%0d want 0/3", rsFull, ALUfreeTag); end
    for (int k = 0; k < 8; k++) if (k != 3) alu_bcast(4'(k), 32'd0);
    n_cmp++; if (ALUfreeTag !== 3'd0 || rsFull !== 1'b0) begin n_bad++; $display("FAIL free_all got free=%0d full=%0b want 0/0", ALUfreeTag, rsFull); end
  endtask

  task automatic test_priority();
    logic [3:0] first, second;
`ifdef ALU_RS_OLDEST_FIRST_EN
    first = 4'h5; second = 4'h2;
`else
    first = 4'h2; second = 4'h5;
`endif
    disp(4'h5, 4'h9, 32'd0, 4'hF, 32'd55, 6'h05);
    disp(4'h2, 4'h9, 32'd0, 4'hF, 32'd22, 6'h06);
    ls_bcast(4'h9, 32'h7);
    tick();
    n_cmp++; if (exEn !== 1'b1 || exTagW !== first) begin n_bad++; $display("FAIL prio_first got en=%0b tw=%h want 1/%h", exEn, exTagW, first); end
    tick();
    n_cmp++; if (exEn !== 1'b1 || exTagW !== second) begin n_bad++; $display("FAIL prio_second got en=%0b tw=%h want 1/%h", exEn, exTagW, second); end
    alu_bcast(4'h2, 32'd0);
    alu_bcast(4'h5, 32'd0);
  endtask

  task automatic test_flush();
    disp(4'h4, 4'hF, 32'd1, 4'hF, 32'd2, 6'h07);
    disp(4'h0, 4'h9, 32'd0, 4'hF, 32'd0, 6'h08);
    n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'h4) begin n_bad++; $display("FAIL flush_pre got en=%0b tw=%h want 1/4", exEn, exTagW); end
    for (int k = 1; k < 4; k++) disp(4'(k), 4'h9, 32'd0, 4'hF, 32'd0, 6'h08);
    misTaken = 1'b1; lsCdbEn = 1'b1; lsCdbTag = 4'h9; lsCdbData = 32'h99;
    disp(4'h5, 4'hF, 32'd0, 4'hF, 32'd0, 6'h09);
    misTaken = 1'b0;
    n_cmp++; if (rsFull !== 1'b0 || ALUfreeTag !== 3'd0 || exEn !== 1'b0) begin n_bad++; $display("FAIL flush got full=%0b free=%0d en=%0b want 0/0/0", rsFull, ALUfreeTag, exEn); end
    ls_bcast(4'h9, 32'h99);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (exEn !== 1'b0) begin n_bad++; $display("FAIL flush_quiet_%0d got %0b want 0", k, exEn); end
    end
  endtask

  task automatic test_reset_mid();
    disp(4'h0, 4'hF, 32'hA, 4'hF, 32'hB, 6'h0A);
    tick();
    n_cmp++; if (exEn !== 1'b1 || exA !== 32'hA) begin n_bad++; $display("FAIL mid_pre got en=%0b a=%h want 1/a", exEn, exA); end
    disp(4'h1, 4'hF, 32'hC, 4'hF, 32'hD, 6'h0B);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (exEn !== 1'b0 || exTagW !== 4'hF || rsFull !== 1'b0 || ALUfreeTag !== 3'd0 || exA !== 32'h0)
      begin n_bad++; $display("FAIL mid_reset got en=%0b tw=%h full=%0b free=%0d a=%h want 0/f/0/0/0", exEn, exTagW, rsFull, ALUfreeTag, exA); end
    #1 rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if (exEn !== 1'b0 || ALUfreeTag !== 3'd0) begin n_bad++; $display("FAIL mid_dropped got en=%0b free=%0d want 0/0", exEn, ALUfreeTag); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_wakeup();
    test_full();
    test_priority();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
